cache_axi_rd_arbiter: RTL and testbench
=======================================

// Module: cache_axi_rd_arbiter
// PURPOSE
//  Shares the single AXI read channel (AR/R) between the I-cache and D-cache refill engines.
//  Holds at most one transaction outstanding; the D-cache has priority and the I-cache has starvation protection.
//  Each cache keeps its own miss stall (i_cache_stall / d_cache_stall to hazard) high until it sees its rd_last.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data beat width
//  ID_I        0   arid/rid value for I-cache transactions (4 bits)
//  ID_D        1   arid/rid value for D-cache transactions (4 bits)
//  STARVE_MAX  4   max consecutive D grants while I waits; 1..15
// PORTS
//  clk         in   1       clock, all state on posedge
//  rst         in   1       synchronous, active-high reset
//  i_rd_req    in   1       I-cache read request, level; held until i_rd_last
//  i_rd_addr   in   ADDR_W  I-cache burst start address, stable while i_rd_req
//  i_rd_len    in   8       I-cache beats-1 (AXI arlen encoding)
//  i_rd_data   out  DATA_W  beat data to I-cache
//  i_rd_valid  out  1       beat valid to I-cache
//  i_rd_last   out  1       final beat to I-cache
//  d_rd_req, d_rd_addr, d_rd_len, d_rd_data, d_rd_valid, d_rd_last: same for the D-cache
//  d_wr_busy   in   1       D-cache write buffer non-empty; D read is not eligible while high
//  arid        out  4       owner ID
//  araddr      out  ADDR_W  latched owner address
//  arlen       out  8       latched owner length
//  arsize      out  3       constant 3'b010
//  arburst     out  2       constant 2'b01 (INCR)
//  arvalid     out  1       AR valid
//  arready     in   1       AR ready
//  rid         in   4       R id
//  rdata       in   DATA_W  R data
//  rlast       in   1       R last
//  rvalid      in   1       R valid
//  rready      out  1       R ready
//  arb_busy    out  1       state != IDLE
//  rid_err     out  1       sticky flag; set on an accepted beat whose rid != owner ID
// BEHAVIOUR
//  FSM: IDLE -> ADDR -> DATA -> GAP -> IDLE. Reset goes to IDLE; all outputs 0 except arsize/arburst constants.
//  - IDLE:
//    - eligible I = i_rd_req; eligible D = d_rd_req & ~d_wr_busy.
//    - Grant rule: D if eligible, unless I is also eligible and starve_cnt == STARVE_MAX, then I.
//    - On grant, latch owner, ID, address and length; go to ADDR. No eligible request: stay in IDLE.
//  - ADDR:
//    - arvalid = 1; arid/araddr/arlen stay stable until arready.
//    - arvalid & arready -> DATA. A request sampled at cycle t gives arvalid at t+1.
//  - DATA:
//    - rready = 1; beat accepted = rvalid & rready.
//    - Beats go combinationally to the owner: x_rd_valid = accepted beat, x_rd_data = rdata, x_rd_last = rlast on that beat.
//    - The non-owner's valid and last stay 0.
//    - An accepted beat with rlast = 1 -> GAP.
//  - GAP: exactly one cycle; requests ignored, so the finishing requester can drop req. Then IDLE.
//  - A beat with rid != owner ID is still routed to the owner and counted; it sets rid_err until rst.
//  - starve_cnt (4 bits):
//    - +1 on a D grant while i_rd_req = 1.
//    - Cleared on an I grant, or on a D grant while i_rd_req = 0.
//    - Saturates at STARVE_MAX.
//  - Simultaneous events:
//    - A req that rises in GAP is served at the next IDLE.
//    - A d_wr_busy rise after a D grant does not cancel that grant.
//  - Requests are never aborted by pipeline flushes; an issued burst always runs to rlast.
//  - rst mid-transaction: next cycle IDLE, arvalid/rready/valids 0, starve_cnt 0, rid_err 0.
//    Outstanding bus beats are the SoC reset's responsibility.
// TESTING
//  1. I-only req, addr 0x1FC00000, len 7 -> arvalid next cycle, arid 0, arlen 7; 8 i_rd_valid beats, i_rd_last on 8th, d_rd_valid never 1.
//  2. I and D req in same cycle -> D granted first (arid 1); after its rlast and one GAP cycle, I is granted (arid 0).
//  3. D and I requesting continuously, STARVE_MAX=4 -> grants D,D,D,D,I,D,... and starve_cnt returns to 0 after the I grant.
//  4. arready held 0 for 5 cycles -> arvalid, araddr, arlen, arid constant all 5 cycles; no beats routed; DATA entered the cycle after arready.
//  5. d_wr_busy=1 with both req -> I granted; D granted at the first IDLE after d_wr_busy falls.
//  6. rst during 3rd beat of a D burst -> next cycle arb_busy 0, arvalid 0, rready 0, d_rd_valid 0, starve_cnt 0; then a fresh I req is served normally.

Source files
------------

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI read channel (AR/R) between the I-cache and D-cache refill engines.
// One burst outstanding at a time; D-cache has priority, and the I-cache has starvation protection.
module cache_axi_rd_arbiter #(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter logic [3:0] ID_I       = 4'd0,
    parameter logic [3:0] ID_D       = 4'd1,
    parameter int         STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [7:0]        i_rd_len,
    output logic [DATA_W-1:0] i_rd_data,
    output logic              i_rd_valid,
    output logic              i_rd_last,
    input  logic              d_rd_req,
    input  logic [ADDR_W-1:0] d_rd_addr,
    input  logic [7:0]        d_rd_len,
    output logic [DATA_W-1:0] d_rd_data,
    output logic              d_rd_valid,
    output logic              d_rd_last,
    input  logic              d_wr_busy,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              arb_busy,
    output logic              rid_err,
    output logic [1:0]        dbg_state_o,
    output logic [3:0]        dbg_starve_cnt_o
);

    // Handshake: AR transfers on arvalid & arready; R beats transfer on rvalid & rready.
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, GAP = 2'd3} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state_q, state_d;
    logic                owner_d_q, owner_d_d;
    logic [3:0]          id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [3:0]          starve_q, starve_d;
    logic                rid_err_q, rid_err_d;

    logic elig_i, elig_d, grant_d, beat;

    assign elig_i  = i_rd_req;
    assign elig_d  = d_rd_req & ~d_wr_busy;
    assign grant_d = elig_d & ~(elig_i & (starve_q == STARVE_LIM));
    assign beat    = (state_q == DATA) & rvalid;

    always_comb begin
        state_d   = state_q;
        owner_d_d = owner_d_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        starve_d  = starve_q;
        rid_err_d = rid_err_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    owner_d_d = 1'b1;
                    id_d      = ID_D;
                    addr_d    = d_rd_addr;
                    len_d     = d_rd_len;
                    // Count only D grants that made a waiting I-cache wait longer.
                    if (i_rd_req)
                        starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
                    else
                        starve_d = 4'd0;
                    state_d = ADDR;
                end else if (elig_i) begin
                    owner_d_d = 1'b0;
                    id_d      = ID_I;
                    addr_d    = i_rd_addr;
                    len_d     = i_rd_len;
                    starve_d  = 4'd0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = DATA;
            end
            DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (rid != id_q) rid_err_d = 1'b1;
                    if (rlast) state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_d_q <= 1'b0;
            id_q      <= 4'd0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            starve_q  <= 4'd0;
            rid_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_d_q <= owner_d_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            starve_q  <= starve_d;
            rid_err_q <= rid_err_d;
        end
    end

    // Beats are routed to the owner whatever their rid; a wrong rid only raises rid_err.
    assign i_rd_valid = beat & ~owner_d_q;
    assign i_rd_last  = beat & ~owner_d_q & rlast;
    assign i_rd_data  = (beat & ~owner_d_q) ? rdata : '0;
    assign d_rd_valid = beat & owner_d_q;
    assign d_rd_last  = beat & owner_d_q & rlast;
    assign d_rd_data  = (beat & owner_d_q) ? rdata : '0;

    assign arid             = id_q;
    assign araddr           = addr_q;
    assign arlen            = len_q;
    assign arsize           = 3'b010;
    assign arburst          = 2'b01;
    assign arb_busy         = (state_q != IDLE);
    assign rid_err          = rid_err_q;
    assign dbg_state_o      = state_q;
    assign dbg_starve_cnt_o = starve_q;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter: a small AXI slave task serves each burst
// and every observed output is compared with hand-derived values.
module tb_cache_axi_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        i_rd_req, d_rd_req, d_wr_busy;
    logic [31:0] i_rd_addr, d_rd_addr;
    logic [7:0]  i_rd_len, d_rd_len;
    logic [31:0] i_rd_data, d_rd_data;
    logic        i_rd_valid, i_rd_last, d_rd_valid, d_rd_last;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready;
    logic        arb_busy, rid_err;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_starve;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] I_ADDR = 32'h1FC0_0000;
    localparam logic [31:0] D_ADDR = 32'h8000_0040;

    cache_axi_rd_arbiter #(
        .ADDR_W(32), .DATA_W(32), .ID_I(4'd0), .ID_D(4'd1), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len),
        .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid), .i_rd_last(i_rd_last),
        .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_len(d_rd_len),
        .d_rd_data(d_rd_data), .d_rd_valid(d_rd_valid), .d_rd_last(d_rd_last),
        .d_wr_busy(d_wr_busy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .arb_busy(arb_busy), .rid_err(rid_err),
        .dbg_state_o(dbg_state), .dbg_starve_cnt_o(dbg_starve)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] beat_data(input bit is_d, input int k);
        return (is_d ? 32'hD000_0000 : 32'h1000_0000) + 32'(k);
    endfunction

    // AXI slave: accept the AR of the expected owner, then return elen+1 beats.
    task automatic serve(input logic [3:0] eid, input logic [31:0] eaddr, input logic [7:0] elen,
                         input bit is_d, output int waited);
        waited = 0;
        while (!arvalid && waited < 20) begin
            tick();
            waited++;
        end
        chk("ar_valid", arvalid, 1);
        chk("ar_id", arid, eid);
        chk("ar_addr", araddr, eaddr);
        chk("ar_len", arlen, elen);
        chk("ar_size", arsize, 3'b010);
        chk("ar_burst", arburst, 2'b01);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("data_state", dbg_state, 2);
        chk("r_ready", rready, 1);
        for (int k = 0; k <= int'(elen); k++) begin
            rvalid = 1'b1;
            rid    = eid;
            rdata  = beat_data(is_d, k);
            rlast  = (k == int'(elen));
            #1;
            chk("own_valid", is_d ? d_rd_valid : i_rd_valid, 1);
            chk("own_data", is_d ? d_rd_data : i_rd_data, beat_data(is_d, k));
            chk("own_last", is_d ? d_rd_last : i_rd_last, (k == int'(elen)));
            chk("other_valid", is_d ? i_rd_valid : d_rd_valid, 0);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        chk("gap_state", dbg_state, 3);
        chk("gap_busy", arb_busy, 1);
        tick();
        chk("idle_after_gap", dbg_state, 0);
    endtask

    logic [3:0] exp_id[6]   = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
    logic [3:0] exp_cnt[6]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

    initial begin
        int w;
        rst = 1'b1;
        i_rd_req = 0; d_rd_req = 0; d_wr_busy = 0;
        i_rd_addr = I_ADDR; d_rd_addr = D_ADDR; i_rd_len = 0; d_rd_len = 0;
        arready = 0; rid = 0; rdata = 0; rlast = 0; rvalid = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", arb_busy, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_ivalid", i_rd_valid, 0);
        chk("rst_dvalid", d_rd_valid, 0);
        chk("rst_ riderr", rid_err, 0);
        chk("rst_starve", dbg_starve, 0);
        chk("rst_arsize", arsize, 3'b010);
        chk("rst_arburst", arburst, 2'b01);

        // 1: I-only burst of 8 beats
        i_rd_req = 1; i_rd_len = 8'd7;
        tick();
        chk("t1_arvalid_next", arvalid, 1);
        serve(4'd0, I_ADDR, 8'd7, 0, w);
        i_rd_req = 0;
        chk("t1_riderr", rid_err, 0);

        // 2: simultaneous requests, D first then I after one GAP cycle
        i_rd_req = 1; i_rd_len = 8'd1; d_rd_req = 1; d_rd_len = 8'd3;
        tick();
        serve(4'd1, D_ADDR, 8'd3, 1, w);
        d_rd_req = 0;
        serve(4'd0, I_ADDR, 8'd1, 0, w);
        chk("t2_i_wait", w, 1);
        i_rd_req = 0;
        chk("t2_starve", dbg_starve, 0);

        // 3: continuous requests, starvation limit 4
        i_rd_req = 1; d_rd_req = 1; i_rd_len = 0; d_rd_len = 0;
        for (int g = 0; g < 6; g++) begin
            serve(exp_id[g], exp_id[g] == 4'd1 ? D_ADDR : I_ADDR, 8'd0, exp_id[g] == 4'd1, w);
            chk("t3_starve", dbg_starve, exp_cnt[g]);
        end
        i_rd_req = 0; d_rd_req = 0;

        // 4: arready held low, beats on R must not be routed
        d_rd_req = 1; d_rd_len = 8'd2;
        tick();
        d_wr_busy = 1;
        rvalid = 1;
        for (int c = 0; c < 5; c++) begin
            chk("t4_arvalid", arvalid, 1);
            chk("t4_arid", arid, 1);
            chk("t4_araddr", araddr, D_ADDR);
            chk("t4_arlen", arlen, 2);
            chk("t4_rready", rready, 0);
            chk("t4_dvalid", d_rd_valid, 0);
            chk("t4_ivalid", i_rd_valid, 0);
            tick();
        end
        rvalid = 0;
        chk("t4_starve", dbg_starve, 0);
        serve(4'd1, D_ADDR, 8'd2, 1, w);
        chk("t4_no_wait", w, 0);
        d_rd_req = 0; d_wr_busy = 0;

        // 5: write buffer busy lets I win; D follows once it drains
        d_wr_busy = 1; i_rd_req = 1; d_rd_req = 1; i_rd_len = 8'd1; d_rd_len = 8'd1;
        tick();
        serve(4'd0, I_ADDR, 8'd1, 0, w);
        i_rd_req = 0;
        tick();
        chk("t5_hold_idle", dbg_state, 0);
        tick();
        chk("t5_hold_idle2", arvalid, 0);
        d_wr_busy = 0;
        tick();
        chk("t5_d_grant", arvalid, 1);
        serve(4'd1, D_ADDR, 8'd1, 1, w);
        d_rd_req = 0;

        // 6: reset during the 3rd beat of a D burst, wrong rid on beat 2
        i_rd_req = 1; d_rd_req = 1; i_rd_len = 8'd2; d_rd_len = 8'd7;
        tick();
        chk("t6_arid", arid, 1);
        chk("t6_starve", dbg_starve, 1);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rid = 4'd1; rdata = 32'hAAAA_0000; rlast = 0;
        tick();
        rid = 4'd5; rdata = 32'hAAAA_0001;
        #1;
        chk("t6_badrid_routed", d_rd_valid, 1);
        tick();
        chk("t6_riderr_set", rid_err, 1);
        rid = 4'd1; rdata = 32'hAAAA_0002;
        rst = 1; d_rd_req = 0;
        tick();
        rst = 0;
        #1;
        chk("t6_busy", arb_busy, 0);
        chk("t6_arvalid", arvalid, 0);
        chk("t6_rready", rready, 0);
        chk("t6_dvalid", d_rd_valid, 0);
        chk("t6_starve_clr", dbg_starve, 0);
        chk("t6_riderr_clr", rid_err, 0);
        rvalid = 0;
        serve(4'd0, I_ADDR, 8'd2, 0, w);
        chk("t6_i_wait", w, 1);
        i_rd_req = 0;
        chk("t6_riderr_end", rid_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
